// File: rtl/lift_input_reader.sv
// Read-side sequencer for the 8-lane lift input buffer: walks rows/lanes, absorbs the
// buffer read latency and streams coefficients through a skid FIFO with valid/ready.
module lift_input_reader #(
    parameter int ADDR_W     = 6,
    parameter int SEL_W      = 3,
    parameter int DATA_W     = 30,
    parameter int FIFO_DEPTH = 4,
    parameter int RAM_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_rows,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] read_address,
    output logic [SEL_W-1:0]  read_sel,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] coeff_out,
    output logic              coeff_valid,
    input  logic              coeff_ready,
    output logic              coeff_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RAM_LAT + 1);
    localparam logic [ADDR_W:0] MAX_ROWS = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic              done_reg, done_next;
    logic [ADDR_W-1:0] last_row_reg;
    logic [ADDR_W-1:0] read_address_reg;
    logic [SEL_W-1:0]  read_sel_reg;

    logic [ADDR_W:0]   rows_clamped;
    logic [ADDR_W:0]   rows_minus_one;
    logic              start_job, start_empty;
    logic              is_final, issue;
    logic [OCC_W-1:0]  inflight, occupancy;

    logic [RAM_LAT-1:0] valid_vec, last_vec;
    logic               push, push_last, pop, head_last;

    logic [DATA_W:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   fifo_count_reg;

    assign rows_clamped   = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
    assign rows_minus_one = rows_clamped - 1'b1;
    assign start_job      = (state_reg == IDLE) && start && (num_rows != '0);
    assign start_empty    = (state_reg == IDLE) && start && (num_rows == '0);
    assign is_final       = (read_address_reg == last_row_reg) && (read_sel_reg == '1);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LAT; i++) begin
            inflight = inflight + OCC_W'(valid_vec[i]);
        end
    end

    // Registered occupancy (FIFO + reads in flight) bounds issue so the FIFO never overflows.
    assign occupancy = OCC_W'(fifo_count_reg) + inflight;
    assign issue     = (state_reg == RUN) && (occupancy < OCC_W'(FIFO_DEPTH));

    // Valid/last pipe that tracks each read through the buffer latency.
    generate
        for (genvar gi = 0; gi < RAM_LAT; gi++) begin : g_stage
            logic v_reg, l_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_reg <= 1'b0;
                    l_reg <= 1'b0;
                end else if (gi == 0) begin
                    v_reg <= issue;
                    l_reg <= issue && is_final;
                end else begin
                    v_reg <= valid_vec[(gi > 0) ? gi - 1 : 0];
                    l_reg <= last_vec[(gi > 0) ? gi - 1 : 0];
                end
            end
            assign valid_vec[gi] = v_reg;
            assign last_vec[gi]  = l_reg;
        end
    endgenerate

    assign push      = valid_vec[RAM_LAT-1];
    assign push_last = last_vec[RAM_LAT-1];

    assign coeff_valid = (fifo_count_reg != '0);
    assign pop         = coeff_valid && coeff_ready;
    assign head_last   = fifo_mem[rd_ptr_reg][DATA_W];
    assign coeff_out   = coeff_valid ? fifo_mem[rd_ptr_reg][DATA_W-1:0] : '0;
    assign coeff_last  = coeff_valid && head_last;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {push_last, read_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_job) begin
                    state_next = RUN;
                end
                done_next = start_empty;
            end
            RUN: begin
                if (issue && is_final) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            done_reg         <= 1'b0;
            last_row_reg     <= '0;
            read_address_reg <= '0;
            read_sel_reg     <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (start_job) begin
                last_row_reg     <= rows_minus_one[ADDR_W-1:0];
                read_address_reg <= '0;
                read_sel_reg     <= '0;
            end else if (issue && !is_final) begin
                // The final address is held so the walk never wraps back to row 0.
                read_sel_reg <= read_sel_reg + 1'b1;
                if (read_sel_reg == '1) begin
                    read_address_reg <= read_address_reg + 1'b1;
                end
            end
        end
    end

    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;
    assign read_address = read_address_reg;
    assign read_sel     = read_sel_reg;

endmodule

// File: tb/tb_lift_input_reader.sv
// Randomized bench for lift_input_reader: a buffer model plus an expected-coefficient
// queue built from the row/lane walk order, checked at every valid cycle.
module tb_lift_input_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  num_rows = '0;
    logic        busy, done;
    logic [5:0]  read_address;
    logic [2:0]  read_sel;
    logic [29:0] read_data = '0;
    logic [29:0] coeff_out;
    logic        coeff_valid;
    logic        coeff_ready = 1'b0;
    logic        coeff_last;

    lift_input_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_rows     (num_rows),
        .busy         (busy),
        .done         (done),
        .read_address (read_address),
        .read_sel     (read_sel),
        .read_data    (read_data),
        .coeff_out    (coeff_out),
        .coeff_valid  (coeff_valid),
        .coeff_ready  (coeff_ready),
        .coeff_last   (coeff_last)
    );

    always #5 clk = ~clk;

    // Buffer model: one-cycle registered read of {row, lane, 21'h0A5A5A}.
    always @(posedge clk) read_data <= {read_address, read_sel, 21'h0A5A5A};

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_start, first_valid_cyc, last_cyc, done_cyc, xfers, done_count;
    logic busy_at_done, busy_seen, valid_seen, model_busy;
    logic rand_ready = 1'b0;
    logic ready_level = 1'b1;
    logic [30:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        coeff_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_seen = 1'b1;
            if (coeff_valid) begin
                valid_seen = 1'b1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(coeff_valid), 0);
                end else begin
                    check("coeff", 32'(coeff_out), 32'(exp_q[0][29:0]));
                    check("last", 32'(coeff_last), 32'(exp_q[0][30]));
                    if (coeff_ready) begin
                        if (exp_q[0][30]) begin
                            last_cyc   = cyc;
                            model_busy = 1'b0;
                        end
                        void'(exp_q.pop_front());
                        xfers++;
                    end
                end
            end
            if (done) begin
                done_count++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
        end
    end

    task automatic clear_stats();
        first_valid_cyc = -1;
        last_cyc        = -1;
        done_cyc        = -1;
        xfers           = 0;
        done_count      = 0;
        busy_seen       = 1'b0;
        valid_seen      = 1'b0;
    endtask

    // Pulses start for one cycle; the model queues the expected walk if the job is accepted.
    task automatic do_start(input int n, input bit new_job);
        @(posedge clk);
        #1;
        if (new_job) clear_stats();
        start    = 1'b1;
        num_rows = 7'(n);
        t_start  = cyc;
        if (!model_busy && n != 0) begin
            int rows = (n > 64) ? 64 : n;
            model_busy = 1'b1;
            for (int r = 0; r < rows; r++) begin
                for (int s = 0; s < 8; s++) begin
                    logic [5:0] rr = 6'(r);
                    logic [2:0] ss = 3'(s);
                    exp_q.push_back({(r == rows - 1) && (s == 7), rr, ss, 21'h0A5A5A});
                end
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_count > 0) break;
        end
        repeat (4) @(posedge clk);
        check("done_count", 32'(done_count), 1);
        check("queue_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        model_busy = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(coeff_valid), 0);
        check("rst_last", 32'(coeff_last), 0);
        check("rst_coeff", 32'(coeff_out), 0);
        check("rst_addr", 32'(read_address), 0);
        check("rst_sel", 32'(read_sel), 0);

        // 1) two rows, ready held high: exact latency
        rand_ready = 1'b0; ready_level = 1'b1;
        do_start(2, 1);
        wait_done(200);
        check("t1_first_valid", 32'(first_valid_cyc), 32'(t_start + 3));
        check("t1_last_cyc", 32'(last_cyc), 32'(t_start + 18));
        check("t1_done_cyc", 32'(done_cyc), 32'(t_start + 19));
        check("t1_busy_at_done", 32'(busy_at_done), 0);
        check("t1_xfers", 32'(xfers), 16);
        $display("job num_rows=2 ready=1: %0d coeffs, done at T+%0d", xfers, done_cyc - t_start);

        // 2) three rows, random backpressure
        rand_ready = 1'b1;
        do_start(3, 1);
        wait_done(2000);
        check("t2_xfers", 32'(xfers), 24);
        $display("job num_rows=3 ready=random: %0d coeffs", xfers);

        // 3) full buffer
        rand_ready = 1'b0;
        do_start(64, 1);
        wait_done(2000);
        check("t3_xfers", 32'(xfers), 512);
        check("t3_final_addr", 32'(read_address), 63);
        check("t3_final_sel", 32'(read_sel), 7);
        $display("job num_rows=64 ready=1: %0d coeffs", xfers);

        // 4) empty job
        do_start(0, 1);
        repeat (6) @(posedge clk);
        check("t4_done_cnt", 32'(done_count), 1);
        check("t4_done_cyc", 32'(done_cyc), 32'(t_start + 1));
        check("t4_busy_seen", 32'(busy_seen), 0);
        check("t4_valid_seen", 32'(valid_seen), 0);
        $display("job num_rows=0: done at T+%0d", done_cyc - t_start);

        // 5) reset mid-job, then a fresh single-row job
        do_start(4, 1);
        for (int i = 0; i < 500 && xfers < 5; i++) @(negedge clk);
        check("t5_pre_reset_xfers", 32'(xfers >= 5), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_busy = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_valid", 32'(coeff_valid), 0);
        check("t5_last", 32'(coeff_last), 0);
        check("t5_coeff", 32'(coeff_out), 0);
        check("t5_addr", 32'(read_address), 0);
        check("t5_sel", 32'(read_sel), 0);
        clear_stats();
        repeat (6) @(posedge clk);
        check("t5_no_stale", 32'(valid_seen), 0);
        do_start(1, 1);
        wait_done(200);
        check("t5_xfers", 32'(xfers), 8);
        $display("job num_rows=1 after reset: %0d coeffs", xfers);

        // 6) start pulsed again mid-job is ignored
        do_start(2, 1);
        repeat (5) @(posedge clk);
        do_start(1, 0);
        wait_done(300);
        check("t6_xfers", 32'(xfers), 16);
        repeat (20) @(posedge clk);
        check("t6_single_done", 32'(done_count), 1);
        $display("job num_rows=2 with ignored restart: %0d coeffs", xfers);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
